// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame bit positions,
// common keyboard command bytes and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    XFER      = 3'd3,
    WAIT_IDLE = 3'd4
  } ps2_state_e;

  // Bit positions counted in device falling edges after the request.
  localparam logic [3:0] DATA_BITS  = 4'd8;
  localparam logic [3:0] PARITY_IDX = 4'd8;
  localparam logic [3:0] STOP_IDX   = 4'd9;
  localparam logic [3:0] ACK_IDX    = 4'd10;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RESP_ACK    = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake and status bundle of the PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       rx_inhibit;
  logic       done;
  logic       ack_err;
  logic       timeout_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, rx_inhibit, done, ack_err, timeout_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, rx_inhibit, done, ack_err, timeout_err
  );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 clock/data pins, deglitches the clock and
// flags filtered falling edges. Shared with the keyboard receiver.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_level,
  output logic data_sync,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             clk_meta_r;
  logic             clk_sync_r;
  logic             data_meta_r;
  logic             data_sync_r;
  logic             clk_level_r;
  logic [CNT_W-1:0] cnt_r;
  logic             fall_r;

  // Two-flop synchronizers plus run-length deglitch of the clock level.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
      clk_level_r <= 1'b1;
      cnt_r       <= {CNT_W{1'b0}};
      fall_r      <= 1'b0;
    end else begin
      clk_meta_r  <= clk_in;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= data_in;
      data_sync_r <= data_meta_r;
      fall_r      <= 1'b0;
      // Any sample agreeing with the accepted level restarts the run.
      if (clk_sync_r == clk_level_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        clk_level_r <= clk_sync_r;
        cnt_r       <= {CNT_W{1'b0}};
        fall_r      <= ~clk_sync_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign clk_level = clk_level_r;
  assign data_sync = data_sync_r;
  assign fall      = fall_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, frame
// shifting on device clock falls, ACK check and inter-edge timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         clk_100mhz,
  input  logic         RSTN,
  ps2_host_tx_if.slave tx_if,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int TIMER_W = $clog2(CNT_MAX);
  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e         state_r;
  logic [7:0]         shift_r;
  logic               parity_r;
  logic [3:0]         bitcnt_r;
  logic [TIMER_W-1:0] timer_r;
  logic               ack_pend_r;
  logic               tx_ready_r;
  logic               busy_r;
  logic               clk_oe_r;
  logic               data_oe_r;
  logic               done_r;
  logic               ack_err_r;
  logic               timeout_err_r;

  logic               clk_level_s;
  logic               data_sync_s;
  logic               fall_s;
  logic               timeout_hit_s;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk_100mhz),
    .rstn      (RSTN),
    .clk_in    (ps2_clk_in),
    .data_in   (ps2_data_in),
    .clk_level (clk_level_s),
    .data_sync (data_sync_s),
    .fall      (fall_s)
  );

  assign timeout_hit_s = (timer_r == TIMEOUT_LAST);

  // Transaction sequencer; every pin enable and status flag is registered here.
  always_ff @(posedge clk_100mhz) begin
    if (!RSTN) begin
      state_r       <= IDLE;
      shift_r       <= 8'h00;
      parity_r      <= 1'b0;
      bitcnt_r      <= 4'd0;
      timer_r       <= {TIMER_W{1'b0}};
      ack_pend_r    <= 1'b0;
      tx_ready_r    <= 1'b1;
      busy_r        <= 1'b0;
      clk_oe_r      <= 1'b0;
      data_oe_r     <= 1'b0;
      done_r        <= 1'b0;
      ack_err_r     <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      done_r        <= 1'b0;
      ack_err_r     <= 1'b0;
      timeout_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          tx_ready_r <= 1'b1;
          busy_r     <= 1'b0;
          clk_oe_r   <= 1'b0;
          data_oe_r  <= 1'b0;
          if (tx_if.tx_valid && tx_ready_r) begin
            shift_r    <= tx_if.tx_data;
            parity_r   <= odd_parity(tx_if.tx_data);
            bitcnt_r   <= 4'd0;
            timer_r    <= {TIMER_W{1'b0}};
            ack_pend_r <= 1'b0;
            tx_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            clk_oe_r   <= 1'b1;
            state_r    <= INHIBIT;
          end else begin
            state_r <= IDLE;
          end
        end
        INHIBIT: begin
          if (timer_r == INHIBIT_LAST) begin
            timer_r   <= {TIMER_W{1'b0}};
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b1;
            state_r   <= REQ;
          end else begin
            timer_r <= timer_r + TIMER_W'(1);
          end
        end
        REQ: begin
          bitcnt_r <= 4'd0;
          timer_r  <= {TIMER_W{1'b0}};
          state_r  <= XFER;
        end
        XFER: begin
          // A fall in the same cycle as the timeout keeps the frame alive.
          if (fall_s) begin
            timer_r  <= {TIMER_W{1'b0}};
            bitcnt_r <= bitcnt_r + 4'd1;
            if (bitcnt_r < DATA_BITS) begin
              data_oe_r <= ~shift_r[bitcnt_r[2:0]];
            end else if (bitcnt_r == PARITY_IDX) begin
              data_oe_r <= ~parity_r;
            end else if (bitcnt_r == STOP_IDX) begin
              data_oe_r <= 1'b0;
            end else if (bitcnt_r == ACK_IDX) begin
              ack_pend_r <= data_sync_s;
              state_r    <= WAIT_IDLE;
            end else begin
              data_oe_r  <= 1'b0;
              ack_pend_r <= 1'b1;
              state_r    <= WAIT_IDLE;
            end
          end else if (timeout_hit_s) begin
            clk_oe_r      <= 1'b0;
            data_oe_r     <= 1'b0;
            done_r        <= 1'b1;
            timeout_err_r <= 1'b1;
            tx_ready_r    <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end else begin
            timer_r <= timer_r + TIMER_W'(1);
          end
        end
        WAIT_IDLE: begin
          if (fall_s) begin
            timer_r <= {TIMER_W{1'b0}};
          end else if (clk_level_s && data_sync_s) begin
            done_r     <= 1'b1;
            ack_err_r  <= ack_pend_r;
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else if (timeout_hit_s) begin
            clk_oe_r      <= 1'b0;
            data_oe_r     <= 1'b0;
            done_r        <= 1'b1;
            timeout_err_r <= 1'b1;
            tx_ready_r    <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end else begin
            timer_r <= timer_r + TIMER_W'(1);
          end
        end
        default: begin
          clk_oe_r   <= 1'b0;
          data_oe_r  <= 1'b0;
          tx_ready_r <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign tx_if.tx_ready    = tx_ready_r;
  assign tx_if.busy        = busy_r;
  assign tx_if.rx_inhibit  = busy_r;
  assign tx_if.done        = done_r;
  assign tx_if.ack_err     = ack_err_r;
  assign tx_if.timeout_err = timeout_err_r;
  assign ps2_clk_oe        = clk_oe_r;
  assign ps2_data_oe       = data_oe_r;

endmodule
